// File: rtl/load_align_unit.sv
// load_align_unit: sequential load-data aligner for the LSU/writeback path.
// Accepts one load, issues one or two aligned bus reads, merges the beats,
// extracts the addressed byte/half/word/dword and sign- or zero-extends it.
// Optional feature macro: MISALIGN_SPLIT_EN. When defined, a load that crosses
// an aligned line is split into two reads and merged. When undefined, such a
// load issues no bus read and returns rsp_err with zero data.
module load_align_unit #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err
);

  localparam int BYTES = XLEN / 8;
  localparam int LOG_B = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [TAG_W-1:0]  r_tag;
  logic [XLEN-1:0]   r_rspData;
  logic              r_rspErr;
`ifdef MISALIGN_SPLIT_EN
  logic              r_cross;
  logic [XLEN-1:0]   r_beat0;
  logic [ADDR_W-1:0] w_nextLineAddr;
`endif

  logic [LOG_B-1:0]  w_reqOff;
  logic [4:0]        w_reqSpan;
  logic              w_reqCross;
  logic              w_reqIllegal;
  logic [ADDR_W-1:0] w_lineAddr;
  logic [XLEN-1:0]   w_beatLo;
  logic [XLEN-1:0]   w_beatHi;
  logic [XLEN-1:0]   w_merged;
  logic [XLEN-1:0]   w_keep;
  logic [XLEN-1:0]   w_result;
  logic [6:0]        w_nBits;
  logic              w_signBit;
  logic              w_lastBeat;

  // A request crosses the line when its last byte lands beyond the aligned word.
  assign w_reqOff   = req_addr[LOG_B-1:0];
  assign w_reqSpan  = 5'(w_reqOff) + (5'd1 << req_size);
  assign w_reqCross = w_reqSpan > 5'(BYTES);

`ifdef MISALIGN_SPLIT_EN
  assign w_reqIllegal   = (XLEN == 32) && (req_size == 2'd3);
  assign w_nextLineAddr = w_lineAddr + ADDR_W'(BYTES);
`else
  assign w_reqIllegal = ((XLEN == 32) && (req_size == 2'd3)) || w_reqCross;
`endif

  assign w_lineAddr = {r_addr[ADDR_W-1:LOG_B], {LOG_B{1'b0}}};

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic; bus responses outside the wait states fall through untouched.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (req_valid) w_nextState = w_reqIllegal ? RESP : REQ0;
      REQ0:  if (mem_rd_ready) w_nextState = WAIT0;
`ifdef MISALIGN_SPLIT_EN
      WAIT0: if (mem_rsp_valid) w_nextState = r_cross ? REQ1 : RESP;
      REQ1:  if (mem_rd_ready) w_nextState = WAIT1;
      WAIT1: if (mem_rsp_valid) w_nextState = RESP;
`else
      WAIT0: if (mem_rsp_valid) w_nextState = RESP;
`endif
      RESP:  if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Pick the beat pair to merge: the live bus beat is the low half unless it is the second beat.
  always_comb begin
    w_beatLo = mem_rsp_data;
    w_beatHi = '0;
`ifdef MISALIGN_SPLIT_EN
    if (r_state == WAIT1) begin
      w_beatLo = r_beat0;
      w_beatHi = mem_rsp_data;
    end
`endif
  end

  assign w_merged = XLEN'({w_beatHi, w_beatLo} >> {r_addr[LOG_B-1:0], 3'b000});
  assign w_nBits  = 7'd8 << r_size;
  assign w_keep   = ~({XLEN{1'b1}} << w_nBits);

  // Select the top bit of the extracted field as the sign source.
  always_comb begin
    w_signBit = 1'b0;
    case (r_size)
      2'd0: w_signBit = w_merged[7];
      2'd1: w_signBit = w_merged[15];
      2'd2: w_signBit = w_merged[31];
      2'd3: w_signBit = w_merged[XLEN-1];
      default: w_signBit = 1'b0;
    endcase
  end

  assign w_result   = (w_merged & w_keep) | ({XLEN{w_signBit & ~r_unsigned}} & ~w_keep);
  assign w_lastBeat = ((r_state == WAIT0) || (r_state == WAIT1)) && (w_nextState == RESP);

  // Capture the request, buffer beats and register the response so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_tag      <= '0;
      r_rspData  <= '0;
      r_rspErr   <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      r_cross    <= 1'b0;
      r_beat0    <= '0;
`endif
    end else begin
      if ((r_state == IDLE) && req_valid) begin
        r_addr     <= req_addr;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_tag      <= req_tag;
        r_rspData  <= '0;
        r_rspErr   <= w_reqIllegal;
`ifdef MISALIGN_SPLIT_EN
        r_cross    <= w_reqCross;
`endif
      end
`ifdef MISALIGN_SPLIT_EN
      if ((r_state == WAIT0) && mem_rsp_valid) r_beat0 <= mem_rsp_data;
`endif
      if (w_lastBeat) r_rspData <= w_result;
    end
  end

  // Bus read address: first aligned line, then the following line (wrapping at the top).
  always_comb begin
    mem_rd_addr = '0;
    if (r_state == REQ0) mem_rd_addr = w_lineAddr;
`ifdef MISALIGN_SPLIT_EN
    if (r_state == REQ1) mem_rd_addr = w_nextLineAddr;
`endif
  end

  assign req_ready    = rst_n && (r_state == IDLE);
  assign mem_rd_valid = (r_state == REQ0) || (r_state == REQ1);
  assign rsp_valid    = (r_state == RESP);
  assign rsp_data     = r_rspData;
  assign rsp_tag      = r_tag;
  assign rsp_err      = r_rspErr;

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Sequential load-data aligner for the LSU/WB path. Accepts one load request, issues one or two aligned bus reads, merges the beats, extracts the addressed byte/half/word/dword, then sign- or zero-extends to XLEN. It generalises the combinational writeback load mux: parametrised width, valid/ready handshakes, and misaligned (line-crossing) loads.

Parameters:
XLEN, 64, datapath and bus width in bits; legal values are 32 and 64; BYTES = XLEN/8.
ADDR_W, 64, address width.
TAG_W, 5, width of the rd tag passed through.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  load request valid.
req_ready  out  1  unit idle, can accept a request.
req_addr  in  ADDR_W  byte address.
req_size  in  2  access size: 0=B, 1=H, 2=W, 3=D.
req_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
req_tag  in  TAG_W  destination register tag.
mem_rd_valid  out  1  bus read request.
mem_rd_ready  in  1  bus accepts read.
mem_rd_addr  out  ADDR_W  aligned read address (low log2(BYTES) bits are 0).
mem_rsp_valid  in  1  bus read data valid.
mem_rsp_data  in  XLEN  aligned read data.
rsp_valid  out  1  result valid.
rsp_ready  in  1  consumer accepts result.
rsp_data  out  XLEN  extended load result.
rsp_tag  out  TAG_W  captured req_tag.
rsp_err  out  1  illegal/unsupported access; rsp_data = 0 when set.

Behaviour:
- Reset (async, rst_n=0): state IDLE. req_ready=0 during reset and 1 after. mem_rd_valid, mem_rd_addr, rsp_valid, rsp_data, rsp_tag and rsp_err are all 0. Reset mid-operation abandons the access; no response is produced.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid, capture addr, size, unsigned and tag, compute off = addr[log2(BYTES)-1:0] and cross = (off + 2^size > BYTES).
  - If the access is illegal, go directly to RESP with rsp_err=1. Illegal means size=3 with XLEN=32, or cross without MISALIGN_SPLIT_EN.
  - Otherwise go to REQ0.
- REQ0: mem_rd_valid=1, mem_rd_addr = addr with the low bits cleared. On mem_rd_ready, go to WAIT0.
- WAIT0: on mem_rsp_valid, latch beat0. If cross, go to REQ1; else go to RESP.
- REQ1: mem_rd_addr = aligned addr + BYTES, computed modulo 2^ADDR_W (wraps to 0). On mem_rd_ready, go to WAIT1.
- WAIT1: on mem_rsp_valid, latch beat1 and go to RESP.
- RESP: rsp_valid=1. rsp_data, rsp_tag and rsp_err are registered and held stable until rsp_ready; then go to IDLE. req_ready=0 in all states except IDLE. No request overlap.
- Data formation:
  - merged = {beat1, beat0} >> (off*8); beat1 is treated as 0 when not crossing.
  - Take the low 8/16/32/64 bits per size.
  - Extend with the top extracted bit (signed) or zeros (unsigned).
  - size=3 ignores req_unsigned.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored.
- mem_rd_valid holds with a stable address until mem_rd_ready.
- Latency, zero wait states:
  - Aligned access: accept at cycle 0, mem_rd_valid in cycle 1, rsp_valid the cycle after mem_rsp_valid.
  - Crossing access: adds a second request/response round.
- Throughput: one load per (beats*2 + 2) cycles minimum.

Optional Feature:
MISALIGN_SPLIT_EN
- Defined: a crossing access is split into two aligned reads and merged as above.
- Undefined: REQ1/WAIT1 are not built. A crossing access issues no bus read and goes IDLE→RESP with rsp_err=1 and rsp_data=0. Non-crossing misaligned accesses (e.g. LH at off=1) remain legal in both builds.

Test Plan:
All cases use XLEN=64. Memory holds [0x1000]=0x8877665544332211 and [0x1008]=0xFFEEDDCCBBAA9988.
1. LB signed @0x1007 -> exactly one read at 0x1000; rsp_data=0xFFFFFFFFFFFFFF88, rsp_err=0, rsp_tag equals req_tag.
2. LW unsigned @0x1004 -> rsp_data=0x0000000088776655. Then LW signed @0x1004 -> 0xFFFFFFFF88776655.
3. LD @0x1005:
   - With MISALIGN_SPLIT_EN: reads at 0x1000 then 0x1008; rsp_data=0xCCBBAA9988887766.
   - Without it: no mem_rd_valid, rsp_err=1, rsp_data=0.
4. Wrap, with MISALIGN_SPLIT_EN: LH @0xFFFFFFFFFFFFFFFF -> second mem_rd_addr=0x0. Result byte0 = top byte of the first beat, byte1 = byte0 of the second beat.
5. Backpressure:
   - Hold mem_rd_ready=0 for 3 cycles -> mem_rd_valid and mem_rd_addr stay stable.
   - Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_tag stay stable; req_ready stays 0.
6. Reset mid-op: assert rst_n=0 in WAIT1 -> all outputs 0 immediately, and a late mem_rsp_valid is ignored. Then LH unsigned @0x1002 -> rsp_data=0x0000000000004433.
